// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// op encodings, FSM state type and counter sizing.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = $clog2(WIDTH_DEF + 1);

    // Counter width for an arbitrary operand width (CNT_W is the default case).
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring step for divide.
// {hi,lo} is the working pair; opnd is the multiplicand or the divisor.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        sum     = '0;
        shifted = '0;
        trial   = '0;
        hi_nxt  = hi;
        lo_nxt  = lo;
        if (!is_div) begin
            sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end else begin
            // Remainder stays below the divisor, so bit WIDTH of trial is a clean borrow flag.
            shifted = {hi, lo[WIDTH-1]};
            trial   = shifted - {1'b0, opnd};
            if (trial[WIDTH]) begin
                hi_nxt = shifted[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end else begin
                hi_nxt = trial[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO pair.
// Operates on magnitudes for WIDTH cycles, then applies the sign fix-up and commits.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = (WIDTH == WIDTH_DEF) ? CNT_W : cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e          state;
    logic [CW-1:0]   count;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic            is_div_r, res_neg, rem_neg, div_zero;

    logic             op_muldiv, op_div, op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign op_muldiv = (Op == OP_MULT) || (Op == OP_MULTU) || (Op == OP_DIV) || (Op == OP_DIVU);
    assign op_div    = (Op == OP_DIV)  || (Op == OP_DIVU);
    assign op_signed = (Op == OP_MULT) || (Op == OP_DIV);
    assign a_neg     = op_signed && SrcA[WIDTH-1];
    assign b_neg     = op_signed && SrcB[WIDTH-1];
    assign a_mag     = a_neg ? -SrcA : SrcA;
    assign b_mag     = b_neg ? -SrcB : SrcB;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_r),
        .hi     (acc_hi),
        .lo     (acc_lo),
        .opnd   (opnd),
        .hi_nxt (step_hi),
        .lo_nxt (step_lo)
    );

    // Divide-by-zero leaves |dividend| in the remainder, so the dividend-sign fix restores SrcA.
    always_comb begin
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        if (!is_div_r) begin
            if (res_neg) {fix_hi, fix_lo} = -{acc_hi, acc_lo};
        end else begin
            if (div_zero)     fix_lo = '1;
            else if (res_neg) fix_lo = -acc_lo;
            if (rem_neg)      fix_hi = -acc_hi;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div_r <= 1'b0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (Start && op_muldiv) begin
                        state    <= CALC;
                        count    <= '0;
                        Busy     <= 1'b1;
                        is_div_r <= op_div;
                        res_neg  <= a_neg ^ b_neg;
                        rem_neg  <= a_neg;
                        div_zero <= op_div && (SrcB == '0);
                        acc_hi   <= '0;
                        acc_lo   <= op_div ? a_mag : b_mag;
                        opnd     <= op_div ? b_mag : a_mag;
                    end else if (Start && Op == OP_MTHI) begin
                        Hi <= SrcA;
                    end else if (Start && Op == OP_MTLO) begin
                        Lo <= SrcA;
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count + 1'b1;
                    if (count == CNT_LAST) state <= FIX;
                end
                FIX: begin
                    Hi    <= fix_hi;
                    Lo    <= fix_lo;
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
